// File: rtl/lstm_gate_act_sequencer.sv
// lstm_gate_act_sequencer: serialises four LSTM gate pre-activations through one shared activation unit
module lstm_gate_act_sequencer #(
  parameter int WIDTH   = 16,
  parameter int FRAC_SZ = 10,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] z_i,
  input  logic [WIDTH-1:0] z_f,
  input  logic [WIDTH-1:0] z_g,
  input  logic [WIDTH-1:0] z_o,
  output logic             act_start,
  output logic [WIDTH-1:0] act_z,
  output logic             act_select,
  input  logic [WIDTH-1:0] act_result,
  input  logic             act_done,
  output logic [WIDTH-1:0] i_gate,
  output logic [WIDTH-1:0] f_gate,
  output logic [WIDTH-1:0] g_gate,
  output logic [WIDTH-1:0] o_gate,
  output logic             valid,
  output logic             busy,
  output logic             err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, OUT} state_t;
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] zr [4];
  logic [WIDTH-1:0] res [4];
  logic accept, hit, tmo, adv;
  if (FRAC_SZ >= WIDTH) begin : g_fmt_chk
    $error("FRAC_SZ must be smaller than WIDTH");
  end
  assign act_start = state == ISSUE;
  assign valid = state == OUT;
  assign busy = state != IDLE;
  assign i_gate = res[0];
  assign f_gate = res[1];
  assign g_gate = res[2];
  assign o_gate = res[3];
  // next-state decode plus the capture/timeout/advance strobes; act_done wins over a same-cycle timeout
  always_comb begin
    accept = state == IDLE && start;
    hit = state == WAIT && act_done;
    tmo = state == WAIT && !act_done && cnt == CW'(TIMEOUT - 1);
    adv = state == GAP && idx != 2'd3;
    idx_n = idx + 2'd1;
    state_n = state;
    case (state)
      IDLE:    state_n = start ? ISSUE : IDLE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = (act_done || tmo) ? GAP : WAIT;
      GAP:     state_n = adv ? ISSUE : OUT;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // operand hold registers, per-gate results, gate index, timeout counter and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      cnt <= '0;
      act_z <= '0;
      act_select <= 1'b0;
      err <= 1'b0;
      zr <= '{default: '0};
      res <= '{default: '0};
    end else begin
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (accept) begin
        zr <= '{z_i, z_f, z_g, z_o};
        idx <= '0;
        act_z <= z_i;
        act_select <= 1'b1;
        err <= 1'b0;
      end
      if (adv) begin
        idx <= idx_n;
        act_z <= zr[idx_n];
        act_select <= idx_n != 2'd2;
      end
      if (hit || tmo) res[idx] <= hit ? act_result : '0;
      if (tmo) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lstm_gate_act_sequencer.sv
// tb_lstm_gate_act_sequencer: vector table plus randomized sets against a mock activation unit and reference model
module tb_lstm_gate_act_sequencer;
  localparam int TO = 64;
  typedef struct {
    logic [3:0][15:0] z;
    logic [3:0][6:0]  lat;
    logic [3:0][15:0] e;
    bit               eerr;
    int               ecyc;
    bit               rej;
    bit               near;
  } vec_t;
  logic clk, reset, start;
  logic [15:0] z_i, z_f, z_g, z_o;
  logic act_start, act_select, act_done;
  logic [15:0] act_z, act_result;
  logic [15:0] i_gate, f_gate, g_gate, o_gate;
  logic valid, busy, err;
  int npass = 0, ntot = 0;
  int gate_n = 0, hold_bad = 0;
  bit func_mode = 0;
  logic [3:0][6:0] lat_cur;
  logic sel_log[$];
  logic [15:0] z_log[$];
  vec_t tbl[$];

  lstm_gate_act_sequencer #(.WIDTH(16), .FRAC_SZ(10), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .z_i(z_i), .z_f(z_f), .z_g(z_g), .z_o(z_o),
    .act_start(act_start), .act_z(act_z), .act_select(act_select),
    .act_result(act_result), .act_done(act_done),
    .i_gate(i_gate), .f_gate(f_gate), .g_gate(g_gate), .o_gate(o_gate),
    .valid(valid), .busy(busy), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  function automatic logic [15:0] act_fn(input logic [15:0] z, input logic s);
    real x, y;
    x = $itor($signed(z)) / 1024.0;
    y = s ? 1.0 / (1.0 + $exp(-x)) : 1.0 - 2.0 / ($exp(2.0 * x) + 1.0);
    return 16'($rtoi(y * 1024.0 + (y < 0.0 ? -0.5 : 0.5)));
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.ecyc = 0;
    r.eerr = 0;
    for (int k = 0; k < 4; k++) begin
      if (int'(v.lat[k]) > TO) begin
        r.e[k] = '0;
        r.eerr = 1;
        r.ecyc += TO + 2;
      end else begin
        r.e[k] = v.z[k] + 16'd1;
        r.ecyc += int'(v.lat[k]) + 2;
      end
    end
    return r;
  endfunction

  // mock activation unit: fixed latency per gate, returns z+1 (or a real activation), checks operand hold
  initial begin
    logic [15:0] hz;
    logic hs;
    int n;
    bit ab;
    act_done = 0;
    act_result = '0;
    forever begin
      @(negedge clk);
      while (act_start && !reset) begin
        hz = act_z;
        hs = act_select;
        n = gate_n < 4 ? int'(lat_cur[gate_n]) : 1;
        gate_n++;
        sel_log.push_back(hs);
        z_log.push_back(hz);
        ab = 0;
        for (int k = 0; k < n; k++) begin
          @(negedge clk);
          if (reset) begin
            ab = 1;
            break;
          end
          if (act_z !== hz || act_select !== hs) hold_bad++;
        end
        if (!ab) begin
          act_result = func_mode ? act_fn(hz, hs) : hz + 16'd1;
          act_done = 1;
          @(negedge clk);
          act_done = 0;
        end
      end
    end
  end

  task automatic run(input vec_t v);
    int cyc, extra, d;
    logic [15:0] gv[4];
    logic [3:0] sb;
    logic [3:0][15:0] zb;
    gate_n = 0;
    hold_bad = 0;
    lat_cur = v.lat;
    func_mode = v.near;
    sel_log.delete();
    z_log.delete();
    {z_o, z_g, z_f, z_i} = v.z;
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    chk("busy_rise", {31'd0, busy}, 1);
    while (!valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (v.rej && cyc == 5) begin
        start = 1;
        {z_o, z_g, z_f, z_i} = ~v.z;
      end else if (v.rej && cyc == 6) start = 0;
    end
    start = 0;
    chk("latency", cyc, v.ecyc);
    gv = '{i_gate, f_gate, g_gate, o_gate};
    for (int k = 0; k < 4; k++) begin
      if (v.near) begin
        d = int'($signed(gv[k])) - int'($signed(v.e[k]));
        chk($sformatf("near_gate%0d", k), {31'd0, d >= -2 && d <= 2}, 1);
      end else chk($sformatf("gate%0d", k), {16'd0, gv[k]}, {16'd0, v.e[k]});
    end
    chk("err", {31'd0, err}, {31'd0, v.eerr});
    @(negedge clk);
    chk("valid_width_busy_fall", {30'd0, valid, busy}, 0);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid) extra++;
    end
    chk("single_valid", extra, 0);
    sb = 'x;
    zb = 'x;
    for (int k = 0; k < sel_log.size() && k < 4; k++) begin
      sb[k] = sel_log[k];
      zb[k] = z_log[k];
    end
    chk("issue_cnt", sel_log.size(), 4);
    chk("sel_seq", {28'd0, sb}, 32'b1011);
    chk("operands_if", zb[1:0], v.z[1:0]);
    chk("operands_go", zb[3:2], v.z[3:2]);
    chk("hold", hold_bad, 0);
  endtask

  initial begin
    vec_t v;
    int cyc;
    tbl.push_back('{z: {16'h0200, 16'hFC00, 16'h0400, 16'h0000}, lat: {7'd20, 7'd20, 7'd20, 7'd20},
                    e: {16'h0201, 16'hFC01, 16'h0401, 16'h0001}, eerr: 1'b0, ecyc: 88, rej: 1'b0, near: 1'b0});
    tbl.push_back('{z: {16'h0200, 16'hFC00, 16'h0400, 16'h0000}, lat: {7'd20, 7'd20, 7'd65, 7'd20},
                    e: {16'h0201, 16'hFC01, 16'h0000, 16'h0001}, eerr: 1'b1, ecyc: 132, rej: 1'b0, near: 1'b0});
    tbl.push_back('{z: {16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF}, lat: {7'd1, 7'd1, 7'd1, 7'd1},
                    e: {16'h1235, 16'h8001, 16'h8000, 16'h0000}, eerr: 1'b0, ecyc: 12, rej: 1'b0, near: 1'b0});
    tbl.push_back('{z: {16'h0010, 16'h0020, 16'h0030, 16'h0040}, lat: {7'd64, 7'd64, 7'd64, 7'd64},
                    e: {16'h0011, 16'h0021, 16'h0031, 16'h0041}, eerr: 1'b0, ecyc: 264, rej: 1'b0, near: 1'b0});
    tbl.push_back('{z: {16'h0100, 16'h0200, 16'h0300, 16'h0400}, lat: {7'd20, 7'd20, 7'd20, 7'd20},
                    e: {16'h0101, 16'h0201, 16'h0301, 16'h0401}, eerr: 1'b0, ecyc: 88, rej: 1'b1, near: 1'b0});
    tbl.push_back('{z: {16'h0AAA, 16'hF555, 16'h0003, 16'hFFFE}, lat: {7'd7, 7'd33, 7'd1, 7'd60},
                    e: {16'h0AAB, 16'hF556, 16'h0004, 16'hFFFF}, eerr: 1'b0, ecyc: 109, rej: 1'b0, near: 1'b0});
    tbl.push_back('{z: {16'h0005, 16'h0006, 16'h0007, 16'h0008}, lat: {7'd65, 7'd65, 7'd65, 7'd65},
                    e: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, eerr: 1'b1, ecyc: 264, rej: 1'b0, near: 1'b0});
    tbl.push_back('{z: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, lat: {7'd12, 7'd12, 7'd12, 7'd12},
                    e: {16'h0200, 16'h0000, 16'h0200, 16'h0200}, eerr: 1'b0, ecyc: 56, rej: 1'b0, near: 1'b1});
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) begin
        v.z[k] = 16'($urandom);
        v.lat[k] = $urandom_range(0, 7) == 0 ? 7'd65 : 7'($urandom_range(1, 60));
      end
      v.rej = 0;
      v.near = 0;
      tbl.push_back(model(v));
    end

    reset = 1;
    start = 0;
    {z_i, z_f, z_g, z_o} = '0;
    lat_cur = '0;
    #23;
    chk("rst_if", {i_gate, f_gate}, 0);
    chk("rst_go", {g_gate, o_gate}, 0);
    chk("rst_ctl", {11'd0, act_start, act_select, valid, busy, err, act_z}, 0);
    @(negedge clk);
    #2 reset = 0;
    @(negedge clk);

    for (int r = 0; r < tbl.size(); r++) run(tbl[r]);

    gate_n = 0;
    func_mode = 0;
    lat_cur = {7'd20, 7'd20, 7'd20, 7'd20};
    {z_o, z_g, z_f, z_i} = {16'h0101, 16'h0202, 16'h0303, 16'h0404};
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("pre_reset_i", {16'd0, i_gate}, 32'h0405);
    #1 reset = 1;
    #1;
    chk("midrst_if", {i_gate, f_gate}, 0);
    chk("midrst_go", {g_gate, o_gate}, 0);
    chk("midrst_ctl", {11'd0, act_start, act_select, valid, busy, err, act_z}, 0);
    repeat (2) @(negedge clk);
    #2 reset = 0;
    @(negedge clk);
    run(tbl[0]);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
